// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared types and helpers for the register write arbiter
package reg_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WR   = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/register bus between the datapath and the write arbiter
interface reg_write_arbiter_if
   import reg_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int IW = clog2(N)
);
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   ack;
   logic           reg_en;
   logic [W-1:0]   reg_d;
   logic [IW-1:0]  gnt_id;
   logic           busy;

   modport master (
      output req, wdata,
      input  ack, reg_en, reg_d, gnt_id, busy
   );

   modport slave (
      input  req, wdata,
      output ack, reg_en, reg_d, gnt_id, busy
   );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
)(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] win,
   output logic [N-1:0]  win_oh
);

   // Walk the offsets from farthest to nearest so the nearest match is assigned last.
   always_comb begin
      any    = 1'b0;
      win    = '0;
      win_oh = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            any = 1'b1;
            win = IW'((int'(ptr) + k) % N);
         end
      end
      if (any) win_oh[win] = 1'b1;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter sequencing two-cycle writes into one holding register
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int IW = clog2(N)
)(
   input logic              clk,
   input logic              rst,
   reg_write_arbiter_if.slave bus
);

   state_t        state, state_n;
   logic [IW-1:0] ptr, ptr_n;
   logic [IW-1:0] gnt, gnt_n;
   logic [N-1:0]  ack, ack_n;
   logic          reg_en, reg_en_n;
   logic          busy, busy_n;
   logic [W-1:0]  reg_d, reg_d_n;

   logic          any;
   logic [IW-1:0] win;
   logic [N-1:0]  win_oh;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .any    (any),
      .win    (win),
      .win_oh (win_oh)
   );

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      gnt_n    = gnt;
      ack_n    = '0;
      reg_en_n = 1'b0;
      busy_n   = 1'b0;
      reg_d_n  = reg_d;
      case (state)
         ST_IDLE: begin
            if (any) begin
               state_n  = ST_WR;
               ptr_n    = (win == IW'(N - 1)) ? '0 : win + 1'b1;
               gnt_n    = win;
               ack_n    = win_oh;
               reg_en_n = 1'b1;
               busy_n   = 1'b1;
               reg_d_n  = bus.wdata[int'(win) * W +: W];
            end
         end
         // No arbitration here: the write completes and we always return to IDLE.
         ST_WR:   state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         ptr    <= '0;
         gnt    <= '0;
         ack    <= '0;
         reg_en <= 1'b0;
         busy   <= 1'b0;
         reg_d  <= '0;
      end else begin
         state  <= state_n;
         ptr    <= ptr_n;
         gnt    <= gnt_n;
         ack    <= ack_n;
         reg_en <= reg_en_n;
         busy   <= busy_n;
         reg_d  <= reg_d_n;
      end
   end

   assign bus.ack    = ack;
   assign bus.reg_en = reg_en;
   assign bus.reg_d  = reg_d;
   assign bus.gnt_id = gnt;
   assign bus.busy   = busy;

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write port of one 16-bit enable-gated holding register among N requesters.
- Arbitrates fairly using round-robin and sequences each write as a two-cycle transaction.
- Drives the register's enable and data inputs, and returns a one-cycle acknowledge to the winning requester.
- Sits between the datapath requesters (ALU result, load path, immediate path, debug port) and the register.

Parameters:
- N, 4, number of requesters (2..8).
- W, 16, data width; must match the register width.
- IW, clog2(N), width of the grant index.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester write request; level, held until ack.
- wdata  in  N*W  requester data; slice i = wdata[i*W +: W]; held stable while req[i]=1.
- ack  out  N  one-hot, one-cycle pulse; the write for that requester is performed this cycle.
- reg_en  out  1  enable to the register; high for exactly one cycle per write.
- reg_d  out  W  data to the register; valid when reg_en=1.
- gnt_id  out  IW  index of the current or last granted requester.
- busy  out  1  high while in the WR state.

Behaviour:

Reset (rst=0, asynchronous):
- state=IDLE.
- ptr=0, ack=0, reg_en=0, reg_d=0, gnt_id=0, busy=0.
- Reset asserted mid-write aborts the transaction: no ack is issued and reg_en drops immediately. The requester keeps req high and is re-arbitrated after reset.

State machine:
- IDLE:
  - If req==0, stay in IDLE; all outputs except gnt_id are 0.
  - Otherwise pick a winner w = the first i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On the edge: reg_d<=wdata[w], gnt_id<=w, ack<=onehot(w), reg_en<=1, busy<=1, ptr<=(w+1) mod N, state<=WR.
- WR:
  - Outputs are registered; reg_en=1 and ack[w]=1 for this single cycle.
  - The register captures reg_d on the edge that ends WR.
  - On that edge: reg_en<=0, ack<=0, busy<=0, state<=IDLE. No arbitration takes place in WR.

Latency and throughput:
- req rising at edge k → ack/reg_en high during cycle k+1 → register updated at edge k+2.
- Peak throughput is 1 write per 2 cycles.

Requester rule:
- A requester may deassert req from the edge ending its ack cycle onward.
- A req still high in the following IDLE cycle is treated as a new request. This is legal: it yields a back-to-back write, still fair because ptr has already advanced past that requester.

Fairness:
- With all N requesting continuously, grants rotate 0,1,…,N-1,0…
- No requester waits more than N-1 grants.

Boundary conditions:
- A requester dropping req while in IDLE without having been granted is legal; it is simply not selected.
- req rising during WR is not seen until the next IDLE cycle.
- ptr wraps from N-1 to 0.
- reg_d holds its last value when reg_en=0.
- wdata changing during WR has no effect, because data is latched in IDLE.

Decomposition:
- Package reg_arb_pkg: the clog2 function, and state encoding constants ST_IDLE=1'b0, ST_WR=1'b1.
- Sub-module rr_pick (purely combinational): inputs req[N], ptr[IW]; outputs any, win[IW], win_oh[N].
- Top level: holds the FSM, ptr, and the output registers.

Test Plan:
- Reset: rst=0 mid-WR with req=4'b0010 → ack=0, reg_en=0 at once; after rst=1, ack[1] is asserted two cycles later.
- Single request: req=4'b0100, wdata[2]=16'hBEEF → cycle+1 reg_en=1, reg_d=16'hBEEF, ack=4'b0100, gnt_id=2; register q=16'hBEEF next edge.
- Round-robin under full load: req=4'b1111, data i=16'h1000+i, held for 8 writes → grant order 0,1,2,3,0,1,2,3; each ack 2 cycles apart.
- Pointer wrap and skip: ptr=3, req=4'b0101 → grant 0, then 2; requester 3 is never acked.
- Late arrival: req=4'b0001 granted; req[3] rises during WR → next IDLE grants 3, not 0 (0 kept req high).
- Data latch: change wdata[1] from 16'h00AA to 16'h5555 during WR → reg_d stays 16'h00AA; register receives 16'h00AA.
